// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx -- oversampling UART receiver
//
// Receives N-bit words, MSB first on the line, framed as
//   start(0) | N data bits | optional parity bit | 1 or 2 stop bits.
// The line is oversampled at OS clk cycles per bit. Each bit is sampled once,
// at mid-bit, timed from the falling start edge.
//
// Parameters
//   N       data word width
//   PARITY  0 none, 1 even, 2 odd, 3 mark, 4 space
//   STOP    0 = one stop bit, 1 = two stop bits
//   OS      clk cycles per bit period (even, >= 4)
//
// Ports
//   clk         in   clock, rising edge
//   nrst        in   asynchronous active-low reset
//   rx          in   serial line, idle high, asynchronous to clk
//   data        out  [N-1:0] last received word (held until next valid)
//   valid       out  one-cycle pulse when a frame completes
//   parity_err  out  parity mismatch on the last frame (0 when PARITY=0)
//   frame_err   out  a stop-bit sample was 0 on the last frame
//   busy        out  high whenever the FSM is not in IDLE
//
// Build option
//   UART_RX_MAJORITY_EN  when defined, every mid-bit sample is replaced by a
//                        2-of-3 majority vote over three consecutive samples.
// ---------------------------------------------------------------------------
module uart_rx #(
  parameter int N      = 8,
  parameter int PARITY = 0,
  parameter int STOP   = 0,
  parameter int OS     = 16
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         rx,
  output logic [N-1:0] data,
  output logic         valid,
  output logic         parity_err,
  output logic         frame_err,
  output logic         busy
);

  localparam int CW   = $clog2(OS);
  localparam int BMAX = (N > 2) ? N : 2;
  localparam int BW   = $clog2(BMAX);

  localparam logic [CW-1:0] CNT_MID   = CW'(OS / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(OS - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(N - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_PAR   = 3'd3,
    S_STOP  = 3'd4
  } state_t;

  // Returns 1 when the received parity bit disagrees with the configured mode.
  function automatic logic parity_bad(input logic [N-1:0] word, input logic pbit);
    logic bad;
    case (PARITY)
      32'sd1:  bad = (^word) ^ pbit;
      32'sd2:  bad = ~((^word) ^ pbit);
      32'sd3:  bad = ~pbit;
      32'sd4:  bad = pbit;
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

  // Synchronizer stages and previous synchronized value (edge detect).
  logic rx_meta_q, rx_meta_d;
  logic rxs_q, rxs_d;
  logic rxs_prev_q, rxs_prev_d;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [N-1:0]  sh_q, sh_d;
  logic          perr_pend_q, perr_pend_d;
  logic          ferr_pend_q, ferr_pend_d;

  logic [N-1:0]  data_q, data_d;
  logic          valid_q, valid_d;
  logic          parity_err_q, parity_err_d;
  logic          frame_err_q, frame_err_d;
  logic          busy_q, busy_d;

  logic          tick_s;
  logic          bit_s;
  logic          ferr_now_s;

  assign tick_s = (cnt_q == CNT_MID);

`ifdef UART_RX_MAJORITY_EN
  // At the mid-bit tick the three taps hold the line at counter values
  // OS/2-2 (rxs_prev_q), OS/2-1 (rxs_q) and OS/2 (rx_meta_q, which becomes
  // rxs_q next cycle), so the vote lands in the same cycle as a single sample.
  // A metastable first stage can only sway one vote of the three.
  assign bit_s = (rxs_prev_q & rxs_q) | (rxs_prev_q & rx_meta_q) | (rxs_q & rx_meta_q);
`else
  assign bit_s = rxs_q;
`endif

  // Frame error including the stop sample taken this cycle.
  assign ferr_now_s = ferr_pend_q | ~bit_s;

  // Synchronizer next values.
  always_comb begin
    rx_meta_d  = rx;
    rxs_d      = rx_meta_q;
    rxs_prev_d = rxs_q;
  end

  // Receiver FSM: next state, counters, shift register and output registers.
  always_comb begin
    state_d      = state_q;
    cnt_d        = (cnt_q == CNT_LAST) ? {CW{1'b0}} : cnt_q + CW'(1'b1);
    bit_d        = bit_q;
    sh_d         = sh_q;
    perr_pend_d  = perr_pend_q;
    ferr_pend_d  = ferr_pend_q;
    data_d       = data_q;
    valid_d      = 1'b0;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;

    case (state_q)
      S_IDLE: begin
        cnt_d = {CW{1'b0}};
        bit_d = {BW{1'b0}};
        if (rxs_prev_q && !rxs_q) begin
          state_d     = S_START;
          perr_pend_d = 1'b0;
          ferr_pend_d = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_START: begin
        if (tick_s) begin
          // A high start sample is a glitch: drop it without touching outputs.
          if (bit_s) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            bit_d   = {BW{1'b0}};
          end
        end else begin
          state_d = S_START;
        end
      end

      S_DATA: begin
        if (tick_s) begin
          // Shift left so the first bit on the line ends up in the MSB.
          sh_d = N'({sh_q, bit_s});
          if (bit_q == BIT_LAST) begin
            bit_d   = {BW{1'b0}};
            state_d = (PARITY != 0) ? S_PAR : S_STOP;
          end else begin
            bit_d = bit_q + BW'(1'b1);
          end
        end else begin
          state_d = S_DATA;
        end
      end

      S_PAR: begin
        if (tick_s) begin
          perr_pend_d = parity_bad(sh_q, bit_s);
          bit_d       = {BW{1'b0}};
          state_d     = S_STOP;
        end else begin
          state_d = S_PAR;
        end
      end

      S_STOP: begin
        if (tick_s) begin
          ferr_pend_d = ferr_now_s;
          // Leaving at mid stop bit leaves half a bit to catch the next edge.
          if (bit_q == STOP_LAST) begin
            state_d      = S_IDLE;
            valid_d      = 1'b1;
            data_d       = sh_q;
            parity_err_d = perr_pend_q;
            frame_err_d  = ferr_now_s;
          end else begin
            bit_d = bit_q + BW'(1'b1);
          end
        end else begin
          state_d = S_STOP;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = {CW{1'b0}};
        bit_d   = {BW{1'b0}};
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rx_meta_q    <= 1'b1;
      rxs_q        <= 1'b1;
      rxs_prev_q   <= 1'b1;
      state_q      <= S_IDLE;
      cnt_q        <= {CW{1'b0}};
      bit_q        <= {BW{1'b0}};
      sh_q         <= {N{1'b0}};
      perr_pend_q  <= 1'b0;
      ferr_pend_q  <= 1'b0;
      data_q       <= {N{1'b0}};
      valid_q      <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      rx_meta_q    <= rx_meta_d;
      rxs_q        <= rxs_d;
      rxs_prev_q   <= rxs_prev_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      sh_q         <= sh_d;
      perr_pend_q  <= perr_pend_d;
      ferr_pend_q  <= ferr_pend_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
    end
  end

  assign data       = data_q;
  assign valid      = valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx -- self-checking bench for uart_rx
//
// Three receivers share clk/nrst, each with its own rx line:
//   u0: N=8, no parity, one stop bit
//   u1: N=8, even parity, one stop bit
//   u2: N=8, no parity, two stop bits
// Every transmitted frame pushes its expected word, flags and valid cycle into
// the scoreboard queue of its receiver; a monitor pops and compares on valid.
// Expected valid cycle: rx is driven at a negedge when cyc=k; rxs falls two
// edges later (t0 = posedge k+2), so valid rises at posedge
//   k + 2 + OS/2 + OS*(bits-1) + 1.
// ---------------------------------------------------------------------------
module tb_uart_rx;

  localparam int OS = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       nrst;
  logic       rx0, rx1, rx2;
  logic [7:0] data0, data1, data2;
  logic       valid0, valid1, valid2;
  logic       parity_err0, parity_err1, parity_err2;
  logic       frame_err0, frame_err1, frame_err2;
  logic       busy0, busy1, busy2;

  uart_rx #(.N(8), .PARITY(0), .STOP(0), .OS(OS)) u0 (
    .clk(clk), .nrst(nrst), .rx(rx0), .data(data0), .valid(valid0),
    .parity_err(parity_err0), .frame_err(frame_err0), .busy(busy0));

  uart_rx #(.N(8), .PARITY(1), .STOP(0), .OS(OS)) u1 (
    .clk(clk), .nrst(nrst), .rx(rx1), .data(data1), .valid(valid1),
    .parity_err(parity_err1), .frame_err(frame_err1), .busy(busy1));

  uart_rx #(.N(8), .PARITY(0), .STOP(1), .OS(OS)) u2 (
    .clk(clk), .nrst(nrst), .rx(rx2), .data(data2), .valid(valid2),
    .parity_err(parity_err2), .frame_err(frame_err2), .busy(busy2));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    int         at;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int v2_prev = 0;
  int v2_last = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic frame_chk(input string tag, input exp_t e, input logic [7:0] d,
                           input logic pe, input logic fe);
    check({tag, "_data"},  {24'd0, d},  {24'd0, e.d});
    check({tag, "_perr"},  {31'd0, pe}, {31'd0, e.pe});
    check({tag, "_ferr"},  {31'd0, fe}, {31'd0, e.fe});
    check({tag, "_cycle"}, 32'(cyc),    32'(e.at));
  endtask

  // Scoreboard monitors: any valid without a pending expectation is a failure.
  always @(negedge clk) begin
    if (valid0) begin
      if (q0.size() == 0) check("u0_valid_unexpected", {31'd0, valid0}, 32'd0);
      else frame_chk("u0", q0.pop_front(), data0, parity_err0, frame_err0);
    end
  end

  always @(negedge clk) begin
    if (valid1) begin
      if (q1.size() == 0) check("u1_valid_unexpected", {31'd0, valid1}, 32'd0);
      else frame_chk("u1", q1.pop_front(), data1, parity_err1, frame_err1);
    end
  end

  always @(negedge clk) begin
    if (valid2) begin
      v2_prev = v2_last;
      v2_last = cyc;
      if (q2.size() == 0) check("u2_valid_unexpected", {31'd0, valid2}, 32'd0);
      else frame_chk("u2", q2.pop_front(), data2, parity_err2, frame_err2);
    end
  end

  task automatic set_rx(input int which, input logic v);
    case (which)
      0:       rx0 = v;
      1:       rx1 = v;
      default: rx2 = v;
    endcase
  endtask

  // Called at a negedge; drives a whole frame and returns at the negedge
  // where the next frame's start bit may begin.
  task automatic drive_frame(input int which, input logic [7:0] w, input logic has_par,
                             input logic par_bit, input int nstop, input logic [1:0] stop_v,
                             input logic exp_pe, input logic exp_fe);
    logic [11:0] bits;
    int          nb;
    exp_t        e;
    bits    = 12'h000;
    bits[0] = 1'b0;
    nb      = 1;
    for (int i = 7; i >= 0; i--) begin
      bits[nb] = w[i];
      nb++;
    end
    if (has_par) begin
      bits[nb] = par_bit;
      nb++;
    end
    for (int i = 0; i < nstop; i++) begin
      bits[nb] = stop_v[i];
      nb++;
    end
    e.d  = w;
    e.pe = exp_pe;
    e.fe = exp_fe;
    e.at = cyc + 2 + OS / 2 + OS * (nb - 1) + 1;
    case (which)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
    for (int i = 0; i < nb; i++) begin
      set_rx(which, bits[i]);
      repeat (OS) @(negedge clk);
    end
    set_rx(which, 1'b1);
  endtask

  initial begin
    int fall;
    nrst = 1'b0;
    rx0  = 1'b1;
    rx1  = 1'b1;
    rx2  = 1'b1;
    repeat (4) @(negedge clk);

    // Reset values.
    check("rst_data0",  {24'd0, data0},       32'd0);
    check("rst_valid0", {31'd0, valid0},      32'd0);
    check("rst_perr0",  {31'd0, parity_err0}, 32'd0);
    check("rst_ferr0",  {31'd0, frame_err0},  32'd0);
    check("rst_busy0",  {31'd0, busy0},       32'd0);
    check("rst_busy2",  {31'd0, busy2},       32'd0);

    nrst = 1'b1;
    repeat (4) @(negedge clk);

    // 0xA5, clean frame: valid at t0+153.
    drive_frame(0, 8'hA5, 1'b0, 1'b0, 1, 2'b01, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    check("a5_received", 32'(q0.size()), 32'd0);

    // 0x81 with a low stop bit: still delivered, frame_err set.
    drive_frame(0, 8'h81, 1'b0, 1'b0, 1, 2'b00, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    check("x81_received", 32'(q0.size()), 32'd0);

    // False start: 3 low cycles, busy must drop by t0+OS/2+1.
    fall = cyc;
    rx0 = 1'b0;
    repeat (3) @(negedge clk);
    rx0 = 1'b1;
    repeat (2) @(negedge clk);
    check("fs_busy_high", {31'd0, busy0}, 32'd1);
    repeat (fall + 2 + OS / 2 + 1 - cyc) @(negedge clk);
    check("fs_busy_low",  {31'd0, busy0}, 32'd0);
    check("fs_data_hold", {24'd0, data0}, 32'h81);
    check("fs_ferr_hold", {31'd0, frame_err0}, 32'd1);
    repeat (2 * OS) @(negedge clk);

    // Even parity: 0x3C has even weight, so parity bit 1 is wrong.
    drive_frame(1, 8'h3C, 1'b1, 1'b1, 1, 2'b01, 1'b1, 1'b0);
    // 0x01 with correct parity bit 1 clears the error.
    drive_frame(1, 8'h01, 1'b1, 1'b1, 1, 2'b01, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    check("par_received", 32'(q1.size()), 32'd0);

    // Two stop bits, back-to-back frames: 11 bits apart.
    drive_frame(2, 8'h3C, 1'b0, 1'b0, 2, 2'b11, 1'b0, 1'b0);
    drive_frame(2, 8'hC3, 1'b0, 1'b0, 2, 2'b11, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    check("b2b_received", 32'(q2.size()), 32'd0);
    check("b2b_spacing",  32'(v2_last - v2_prev), 32'(11 * OS));

    // Second stop bit low only.
    drive_frame(2, 8'h0F, 1'b0, 1'b0, 2, 2'b01, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    check("stop2_received", 32'(q2.size()), 32'd0);

    // Reset in the middle of DATA of 0xFF: frame aborted, outputs cleared.
    rx0 = 1'b0;
    repeat (OS) @(negedge clk);
    rx0 = 1'b1;
    repeat (3 * OS) @(negedge clk);
    nrst = 1'b0;
    @(negedge clk);
    check("mid_rst_busy",  {31'd0, busy0},      32'd0);
    check("mid_rst_data",  {24'd0, data0},      32'd0);
    check("mid_rst_ferr",  {31'd0, frame_err0}, 32'd0);
    check("mid_rst_valid", {31'd0, valid0},     32'd0);
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    repeat (12 * OS) @(negedge clk);
    check("post_rst_idle", {31'd0, busy0}, 32'd0);

    // Receiver recovers on the next frame.
    drive_frame(0, 8'h55, 1'b0, 1'b0, 1, 2'b01, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    check("x55_received", 32'(q0.size()), 32'd0);

    repeat (OS) @(negedge clk);
    check("final_q0", 32'(q0.size()), 32'd0);
    check("final_q1", 32'(q1.size()), 32'd0);
    check("final_q2", 32'(q2.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter N, 8, data word width in bits.
REQ-002 Parameter PARITY, 0, parity mode: 0 none, 1 even, 2 odd, 3 mark, 4 space.
REQ-003 Parameter STOP, 0, stop bits: 0 = one, 1 = two.
REQ-004 Parameter OS, 16, clk cycles per bit period; even, >= 4.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 nrst  input  1  reset, asynchronous, active-low.
REQ-007 rx  input  1  serial line; idle high; asynchronous to clk.
REQ-008 data  output  N  last received word, MSB first on the line.
REQ-009 valid  output  1  single-cycle pulse when a frame completes.
REQ-010 parity_err  output  1  parity mismatch on the last frame; always 0 when PARITY=0.
REQ-011 frame_err  output  1  a stop-bit sample was 0 on the last frame.
REQ-012 busy  output  1  high in every state except IDLE.

Function
REQ-013 rx SHALL pass through a 2-flop synchronizer; all logic uses the synchronized value rxs.
- Synchronizer flops load 1 on reset.
REQ-014 FSM states SHALL be IDLE, START, DATA, PAR, STOP.
- Counters: sample counter 0..OS-1; bit counter sized for max(N, 2).
REQ-015 Start detection in IDLE: a 1->0 transition on rxs moves the FSM to START with the sample counter cleared.
- This edge defines cycle t0.
REQ-016 Bit sampling: each bit SHALL be sampled once, at mid-bit.
- Start bit: sampled at t0+OS/2.
- Each following bit: sampled OS cycles after the previous sample.
REQ-017 START: a sample of 1 is a false start.
- Return to IDLE.
- No valid pulse and no flag change.
- A sample of 0 moves the FSM to DATA.
REQ-018 DATA: each sample shifts into a register as {sh[N-2:0], sample}, so the first received bit ends in data[N-1].
- After N samples, go to PAR if PARITY!=0, else STOP.
REQ-019 PAR: the sampled bit SHALL be checked as follows.
- Even: error if XOR(word, bit) = 1.
- Odd: error if XOR(word, bit) = 0.
- Mark: error if bit = 0.
- Space: error if bit = 1.
REQ-020 STOP: sample 1 (STOP=0) or 2 (STOP=1) stop bits; any 0 sample sets the frame error for this frame.
REQ-021 Cycle after the final stop-bit sample:
- data, parity_err and frame_err update together.
- valid = 1 for exactly that one cycle.
- The FSM is in IDLE in that same cycle.
REQ-022 data, parity_err and frame_err SHALL hold their values until the next valid pulse.
REQ-023 Because IDLE is re-entered at the middle of the stop bit, a start edge arriving immediately after the stop bit SHALL be detected (back-to-back frames).
REQ-024 Latency check (N=8, PARITY=0, STOP=0, OS=16): valid high at t0+153.
REQ-025 Frames with frame_err=1 SHALL still pulse valid and deliver data.

Reset
REQ-026 While nrst=0, the block SHALL hold the following values.
- FSM: IDLE.
- Counters: 0.
- data: 0.
- valid, parity_err, frame_err, busy: 0.
REQ-027 Reset asserted mid-frame SHALL abort the frame with no valid pulse.
- After release, the block waits for a new 1->0 transition.

Configuration
REQ-028 Macro UART_RX_MAJORITY_EN, when defined, SHALL replace each single mid-bit sample with a 2-of-3 majority vote.
- Samples taken at sample-counter values OS/2-2, OS/2-1 and OS/2.
- Vote result available at the same cycle as REQ-016.
REQ-029 Macro UART_RX_MAJORITY_EN undefined: the single sample at OS/2-1 is used, with no extra logic.

Verification
REQ-030 Frame 0xA5, PARITY=0, one stop bit, OS=16 -> valid pulse at t0+153; data=0xA5; both error flags 0.
REQ-031 rx low for 3 cycles, then high -> no valid pulse; busy returns to 0 by t0+OS/2+1.
REQ-032 PARITY=1, word 0x3C sent with parity bit 1 (wrong) -> data=0x3C, parity_err=1; next correct frame clears it.
REQ-033 0x81 with stop bit 0 -> valid, data=0x81, frame_err=1.
REQ-034 Back-to-back 0x3C then 0xC3, STOP=1 -> two valid pulses 11*16 cycles apart; data correct each time.
REQ-035 nrst pulsed during DATA of 0xFF -> no valid pulse; a following 0x55 is received correctly.
